// File: rtl/ip_cu_ctrl.sv
// Calculation Unit sequencer: accepts one ADD/SUB/MUL/DIV request at a time,
// counts datapath iterations, and drives the CU state strobes and op enables.
module ip_cu_ctrl #(
    parameter int ALU_SZ = 8,
    parameter int EXD_SZ = 1,
    parameter int CNT_SZ = 5
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              op_req,
    input  logic [1:0]        op_code,
    input  logic              op_hold,
    input  logic              op_abort,
    output logic              op_ack,
    output logic              op_done,
    output logic              op_busy,
    output logic              op_ini_sm,
    output logic              op_act_sm,
    output logic              op_rdy_sm,
    output logic              op_halt_sm,
    output logic              add_en,
    output logic              sub_en,
    output logic              mul_en,
    output logic              div_en,
    output logic [CNT_SZ-1:0] op_cnt
);

    // state | meaning
    // IDLE  | waiting for op_req; enables and counter clear
    // INI   | one cycle: load iteration count, ADD/SUB compute here
    // BUSY  | one datapath iteration per cycle, counter counts down
    // HALT  | paused by op_hold; counter and enables frozen
    // RDY   | one cycle: product valid, op_done pulses
    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        INI  = 5'b00010,
        BUSY = 5'b00100,
        HALT = 5'b01000,
        RDY  = 5'b10000
    } state_t;

    localparam logic [CNT_SZ-1:0] MUL_N = CNT_SZ'(ALU_SZ);
    localparam logic [CNT_SZ-1:0] DIV_N = CNT_SZ'(ALU_SZ + EXD_SZ);
    localparam logic [CNT_SZ-1:0] CNT_ONE = CNT_SZ'(1);

    state_t            state_q, state_d;
    logic [CNT_SZ-1:0] cnt_q, cnt_d;
    logic [3:0]        en_q, en_d;  // {div, mul, sub, add}
    logic [CNT_SZ-1:0] ini_n;

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
        end
    end

    // The latched enable already identifies the operation, so N derives from it.
    always_comb begin
        ini_n = '0;
        if (en_q[2])
            ini_n = MUL_N;
        else if (en_q[3])
            ini_n = DIV_N;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        if (state_q != IDLE && op_abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            en_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (op_req) begin
                        state_d       = INI;
                        en_d          = '0;
                        en_d[op_code] = 1'b1;
                    end
                end
                INI: begin
                    cnt_d   = ini_n;
                    state_d = (ini_n == '0) ? RDY : BUSY;
                end
                BUSY: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_ONE)
                        state_d = RDY;
                    else if (op_hold)
                        state_d = HALT;
                end
                HALT: begin
                    if (!op_hold)
                        state_d = BUSY;
                end
                RDY: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    en_d    = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    en_d    = '0;
                end
            endcase
        end
    end

    assign op_ack     = (state_q == IDLE) && op_req;
    assign op_busy    = (state_q != IDLE);
    assign op_ini_sm  = (state_q == INI);
    assign op_act_sm  = (state_q == INI) || (state_q == BUSY) || (state_q == RDY);
    assign op_rdy_sm  = (state_q == RDY);
    assign op_halt_sm = (state_q == HALT);
    assign op_done    = (state_q == RDY);
    assign add_en     = en_q[0];
    assign sub_en     = en_q[1];
    assign mul_en     = en_q[2];
    assign div_en     = en_q[3];
    assign op_cnt     = cnt_q;

endmodule

// File: tb/tb_ip_cu_ctrl.sv
// Directed bench for ip_cu_ctrl: vector table for the four operations plus
// hand-written hold, abort, reset and parameter-sweep sequences.
module tb_ip_cu_ctrl;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic       prst, op_req, op_hold, op_abort;
    logic [1:0] op_code;
    logic       op_ack, op_done, op_busy, op_ini_sm, op_act_sm, op_rdy_sm, op_halt_sm;
    logic       add_en, sub_en, mul_en, div_en;
    logic [4:0] op_cnt;

    logic       req2, hold2, abort2;
    logic [1:0] code2;
    logic       ack2, done2, busy2, ini2, act2, rdy2, halt2;
    logic       add2, sub2, mul2, div2;
    logic [4:0] cnt2;

    ip_cu_ctrl dut (
        .pclk(pclk), .prst(prst), .op_req(op_req), .op_code(op_code),
        .op_hold(op_hold), .op_abort(op_abort), .op_ack(op_ack), .op_done(op_done),
        .op_busy(op_busy), .op_ini_sm(op_ini_sm), .op_act_sm(op_act_sm),
        .op_rdy_sm(op_rdy_sm), .op_halt_sm(op_halt_sm), .add_en(add_en),
        .sub_en(sub_en), .mul_en(mul_en), .div_en(div_en), .op_cnt(op_cnt)
    );

    ip_cu_ctrl #(.ALU_SZ(16), .EXD_SZ(4), .CNT_SZ(5)) dut_wide (
        .pclk(pclk), .prst(prst), .op_req(req2), .op_code(code2),
        .op_hold(hold2), .op_abort(abort2), .op_ack(ack2), .op_done(done2),
        .op_busy(busy2), .op_ini_sm(ini2), .op_act_sm(act2),
        .op_rdy_sm(rdy2), .op_halt_sm(halt2), .add_en(add2),
        .sub_en(sub2), .mul_en(mul2), .div_en(div2), .op_cnt(cnt2)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] code;
        int         n;
        logic [3:0] en;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle and check the enable invariants on both instances.
    task automatic tick();
        @(posedge pclk);
        #1;
        checks++;
        if (!$onehot0({div_en, mul_en, sub_en, add_en}) || !$onehot0({div2, mul2, sub2, add2}) ||
            ({div_en, mul_en, sub_en, add_en} != 4'b0 && !op_busy)) begin
            errors++;
            $display("FAIL enable_invariant: got %b/%b busy %b at %0t",
                     {div_en, mul_en, sub_en, add_en}, {div2, mul2, sub2, add2}, op_busy, $time);
        end
    endtask

    // Accept an operation from IDLE; returns in the INI cycle (T+1).
    task automatic start_op(input logic [1:0] code);
        op_req  = 1'b1;
        op_code = code;
        #1;
        chk("start_ack", {31'b0, op_ack}, 32'd1);
        tick();
        op_req = 1'b0;
    endtask

    task automatic wait_done(input int start_k, output int k);
        k = start_k;
        while (!op_done && k < start_k + 40) begin
            tick();
            k++;
        end
    endtask

    task automatic no_done_for(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            seen = seen | op_done;
        end
        chk(name, {31'b0, seen}, 32'd0);
    endtask

    function automatic logic [31:0] all_out();
        return {19'b0, op_ack, op_done, op_busy, op_ini_sm, op_act_sm, op_rdy_sm, op_halt_sm,
                add_en, sub_en, mul_en, div_en, 1'b0, |op_cnt};
    endfunction

    initial begin
        int k;
        vecs[0] = '{code: 2'd0, n: 0, en: 4'b0001};
        vecs[1] = '{code: 2'd1, n: 0, en: 4'b0010};
        vecs[2] = '{code: 2'd2, n: 8, en: 4'b0100};
        vecs[3] = '{code: 2'd3, n: 9, en: 4'b1000};

        prst = 1'b1; op_req = 1'b0; op_code = 2'd0; op_hold = 1'b0; op_abort = 1'b0;
        req2 = 1'b0; code2 = 2'd0; hold2 = 1'b0; abort2 = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", all_out(), 32'd0);
        chk("reset_cnt", {27'b0, op_cnt}, 32'd0);
        prst = 1'b0;
        tick();

        // Back-to-back table; op_req stays high while busy and must not be acked.
        for (int i = 0; i < 4; i++) begin
            op_req  = 1'b1;
            op_code = vecs[i].code;
            #1;
            chk("acc_ack", {31'b0, op_ack}, 32'd1);
            tick();
            #1;
            chk("ini_strobes", {28'b0, op_ini_sm, op_act_sm, op_busy, op_done}, 32'b1110);
            chk("ini_no_ack", {31'b0, op_ack}, 32'd0);
            chk("ini_en", {28'b0, div_en, mul_en, sub_en, add_en}, {28'b0, vecs[i].en});
            for (int c = 2; c <= 2 + vecs[i].n; c++) begin
                tick();
                if (c == 2 + vecs[i].n) op_req = 1'b0;
                #1;
                if (c < 2 + vecs[i].n) begin
                    chk("busy_cnt", {27'b0, op_cnt}, 32'(vecs[i].n - (c - 2)));
                    chk("busy_flags", {28'b0, op_act_sm, op_done, op_ack, op_halt_sm}, 32'b1000);
                end else begin
                    chk("rdy_flags", {28'b0, op_rdy_sm, op_done, op_act_sm, op_ini_sm}, 32'b1110);
                    chk("rdy_en", {28'b0, div_en, mul_en, sub_en, add_en}, {28'b0, vecs[i].en});
                end
            end
            tick();
            chk("idle_after", {28'b0, op_busy, op_done, |{div_en, mul_en, sub_en, add_en}, 1'b0}, 32'd0);
        end

        // Hold at op_cnt==5 for three cycles.
        start_op(2'd2);
        repeat (4) tick();
        op_hold = 1'b1;
        #1;
        chk("hold_cnt5", {27'b0, op_cnt}, 32'd5);
        for (int h = 0; h < 3; h++) begin
            tick();
            if (h == 2) op_hold = 1'b0;
            #1;
            chk("halt_flags", {27'b0, op_halt_sm, op_act_sm, op_done, mul_en, 1'b0}, 32'b10010);
            chk("halt_cnt", {27'b0, op_cnt}, 32'd4);
        end
        wait_done(8, k);
        chk("hold_latency", 32'(k), 32'd13);
        tick();

        // Hold on the last iteration: completion wins.
        start_op(2'd2);
        repeat (8) tick();
        op_hold = 1'b1;
        #1;
        chk("last_cnt1", {27'b0, op_cnt}, 32'd1);
        tick();
        op_hold = 1'b0;
        chk("last_hold_rdy", {29'b0, op_rdy_sm, op_done, op_halt_sm}, 32'b110);
        tick();

        // Abort in BUSY.
        start_op(2'd3);
        repeat (3) tick();
        op_abort = 1'b1;
        tick();
        op_abort = 1'b0;
        chk("abort_busy", all_out(), 32'd0);
        no_done_for("abort_busy_no_done", 12);

        // Abort in HALT.
        start_op(2'd2);
        tick();
        op_hold = 1'b1;
        tick();
        chk("pre_abort_halt", {31'b0, op_halt_sm}, 32'd1);
        op_abort = 1'b1;
        tick();
        op_abort = 1'b0;
        op_hold  = 1'b0;
        chk("abort_halt", all_out(), 32'd0);
        no_done_for("abort_halt_no_done", 12);

        // Abort in INI of an ADD, which would otherwise complete next cycle.
        start_op(2'd0);
        op_abort = 1'b1;
        tick();
        op_abort = 1'b0;
        chk("abort_ini", all_out(), 32'd0);
        no_done_for("abort_ini_no_done", 4);

        // Abort coinciding with the last iteration.
        start_op(2'd2);
        repeat (8) tick();
        chk("abort_last_cnt", {27'b0, op_cnt}, 32'd1);
        op_abort = 1'b1;
        tick();
        op_abort = 1'b0;
        chk("abort_last", all_out(), 32'd0);
        no_done_for("abort_last_no_done", 4);

        // Reset held for two cycles mid-MUL.
        start_op(2'd2);
        repeat (3) tick();
        prst = 1'b1;
        tick();
        chk("rst_mid_1", all_out(), 32'd0);
        tick();
        chk("rst_mid_2", all_out(), 32'd0);
        prst = 1'b0;
        no_done_for("rst_mid_no_done", 12);

        // Wide instance: MUL at T+18, DIV at T+22.
        for (int w = 0; w < 2; w++) begin
            req2  = 1'b1;
            code2 = (w == 0) ? 2'd2 : 2'd3;
            #1;
            chk("wide_ack", {31'b0, ack2}, 32'd1);
            tick();
            req2 = 1'b0;
            k = 1;
            while (!done2 && k < 60) begin
                tick();
                k++;
            end
            chk(w == 0 ? "wide_mul_latency" : "wide_div_latency", 32'(k), (w == 0) ? 32'd18 : 32'd22);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
